// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore control sequencer: fetch T0-T2, then R3/MD/R2 execute steps T3-T6.
// Optional illegal-opcode trap into HALT is compiled in with CTRL_ILLEGAL_TRAP_EN.
module control_sequencer #(
  parameter bit ILLEGAL_NOP = 1'b1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Start,
  input  logic        Stop,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  alu_op,
  output logic        Run,
  output logic        Done,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [4:0] op;
  logic       is_r3, is_md, is_r2;
  logic       unused_ir;
  state_t     fin_next, illegal_next;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_r3     = (op <= 5'd11);
  assign is_md     = (op == 5'd15) || (op == 5'd16);
  assign is_r2     = (op == 5'd17) || (op == 5'd18);
  assign fin_next  = Stop ? IDLE : T0;

  // Trap wins when compiled in; otherwise a NOP retires like a normal final step.
  assign illegal_next = TrapEn ? HALT : ((ILLEGAL_NOP && !Stop) ? T0 : IDLE);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0; PCin    = 1'b0; IncPC    = 1'b0; MARin = 1'b0;
    Read     = 1'b0; MDRin   = 1'b0; MDRout   = 1'b0; IRin  = 1'b0;
    Gra      = 1'b0; Grb     = 1'b0; Grc      = 1'b0; Rin   = 1'b0;
    Rout     = 1'b0; Yin     = 1'b0; Zin      = 1'b0; Zlowout = 1'b0;
    ZHighout = 1'b0; HIin    = 1'b0; LOin     = 1'b0;
    alu_op   = 5'd0; Run     = 1'b0; Done     = 1'b0; Illegal = 1'b0;
    case (state_q)
      IDLE: if (Start && !Stop) state_d = T0;
      T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = T1;
      end
      T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = T2;
      end
      T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = T3;
      end
      T3: begin
        Run = 1'b1;
        if (is_r3 || is_md) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          state_d = T4;
        end else if (is_r2) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
          state_d = T4;
        end else begin
          Done = 1'b1; Illegal = 1'b1;
          state_d = illegal_next;
        end
      end
      T4: begin
        Run = 1'b1;
        if (is_r3 || is_md) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op;
          state_d = T5;
        end else if (is_r2) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
          state_d = fin_next;
        end else begin
          state_d = IDLE;
        end
      end
      T5: begin
        Run = 1'b1;
        if (is_r3) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
          state_d = fin_next;
        end else if (is_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
          state_d = T6;
        end else begin
          state_d = IDLE;
        end
      end
      T6: begin
        Run = 1'b1; ZHighout = 1'b1; HIin = 1'b1; Done = 1'b1;
        state_d = fin_next;
      end
      HALT: Illegal = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule
